// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl
// MMIO control and readout front-end for the core's instruction counter.
// It keeps a free-running cycle counter and, on every CYCLE read, snapshots
// the instruction count on the same edge. Software therefore gets a
// consistent CYCLE/INSTR pair for CPI measurement.
//
// Register map (byte offset, only addr[3:2] decoded):
//   0x0 CYCLE  RO  live cycle counter; reading it latches the INSTR snapshot
//   0x4 INSTR  RO  instruction snapshot; reading it clears snap_valid
//   0x8 CTRL   RW  bit0 freeze, bit1 clear (write-1 action, reads 0)
//   0xC STATUS RO  bit0 freeze, bit1 snap_valid
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   retire_valid      an instruction retires this cycle
//   instr_cnt         current count from the instruction counter
//   instr_stop        to counter: hold count (comb: ~retire_valid | freeze)
//   counter_rst       to counter: synchronous clear request (high in reset)
//   mmio_req_*        request channel (valid/ready handshake)
//   mmio_wdata        write data
//   mmio_resp_valid   one-cycle response strobe, no backpressure
//   mmio_rdata        read data, valid with mmio_resp_valid
module perf_counter_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] instr_cnt,
  output logic            instr_stop,
  output logic            counter_rst,
  input  logic            mmio_req_valid,
  output logic            mmio_req_ready,
  input  logic            mmio_req_we,
  input  logic [3:0]      mmio_req_addr,
  input  logic [XLEN-1:0] mmio_wdata,
  output logic            mmio_resp_valid,
  output logic [XLEN-1:0] mmio_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0]      REG_CYCLE  = 2'd0;
  localparam logic [1:0]      REG_INSTR  = 2'd1;
  localparam logic [1:0]      REG_CTRL   = 2'd2;
  localparam logic [1:0]      REG_STATUS = 2'd3;
  localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic              freeze_r, freeze_nxt_s;
  logic [XLEN-1:0]   cycle_r, cycle_nxt_s;
  logic [XLEN-1:0]   snap_r, snap_nxt_s;
  logic              snap_valid_r, snap_valid_nxt_s;
  logic [XLEN-1:0]   rdata_r, rdata_nxt_s;
  logic              resp_valid_r;
  logic              ready_r;
  logic              counter_rst_r;
  logic              accept_s;
  logic [1:0]        reg_sel_s;
  logic              unused_s;

  // Byte-lane bits of the address and upper write-data bits carry no meaning.
  assign unused_s   = ^{mmio_req_addr[1:0], mmio_wdata[XLEN-1:2]};

  assign reg_sel_s  = mmio_req_addr[3:2];
  assign accept_s   = mmio_req_valid & ready_r;

  // Hold the downstream count when nothing retires or software froze it.
  assign instr_stop = ~retire_valid | freeze_r;

  assign counter_rst     = counter_rst_r;
  assign mmio_req_ready  = ready_r;
  assign mmio_resp_valid = resp_valid_r;
  assign mmio_rdata      = rdata_r;

  // Next-state, register-update and read-data decode.
  always_comb begin
    state_nxt_s      = state_r;
    freeze_nxt_s     = freeze_r;
    snap_nxt_s       = snap_r;
    snap_valid_nxt_s = snap_valid_r;
    rdata_nxt_s      = '0;
    // freeze seen here is the pre-write value, so a freezing CTRL write
    // still lets the cycle counter advance on its own accept edge.
    if (freeze_r) begin
      cycle_nxt_s = cycle_r;
    end else begin
      cycle_nxt_s = cycle_r + ONE;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RESP;
          if (mmio_req_we) begin
            // Writes to RO registers fall through with rdata 0.
            if (reg_sel_s == REG_CTRL) begin
              freeze_nxt_s = mmio_wdata[0];
              if (mmio_wdata[1]) begin
                state_nxt_s = ST_CLR;
              end else begin
                state_nxt_s = ST_RESP;
              end
            end else begin
              freeze_nxt_s = freeze_r;
            end
          end else begin
            case (reg_sel_s)
              REG_CYCLE: begin
                rdata_nxt_s      = cycle_r;
                snap_nxt_s       = instr_cnt;
                snap_valid_nxt_s = 1'b1;
              end
              REG_INSTR: begin
                rdata_nxt_s      = snap_r;
                snap_valid_nxt_s = 1'b0;
              end
              REG_CTRL:   rdata_nxt_s = {{(XLEN-1){1'b0}}, freeze_r};
              REG_STATUS: rdata_nxt_s = {{(XLEN-2){1'b0}}, snap_valid_r, freeze_r};
              default:    rdata_nxt_s = '0;
            endcase
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        cycle_nxt_s      = '0;
        snap_nxt_s       = '0;
        snap_valid_nxt_s = 1'b0;
        state_nxt_s      = ST_RESP;
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered handshake outputs; outputs are decoded
  // from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      freeze_r      <= 1'b0;
      cycle_r       <= '0;
      snap_r        <= '0;
      snap_valid_r  <= 1'b0;
      rdata_r       <= '0;
      resp_valid_r  <= 1'b0;
      ready_r       <= 1'b0;
      counter_rst_r <= 1'b1;
    end else begin
      state_r       <= state_nxt_s;
      freeze_r      <= freeze_nxt_s;
      cycle_r       <= cycle_nxt_s;
      snap_r        <= snap_nxt_s;
      snap_valid_r  <= snap_valid_nxt_s;
      rdata_r       <= rdata_nxt_s;
      resp_valid_r  <= (state_nxt_s == ST_RESP);
      ready_r       <= (state_nxt_s == ST_IDLE);
      counter_rst_r <= (state_nxt_s == ST_CLR);
    end
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed testbench for perf_counter_ctrl. Includes a behavioural model of
// the downstream instruction counter driven by instr_stop / counter_rst.
module tb_perf_counter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        retire_valid;
  logic [31:0] instr_cnt;
  logic        instr_stop;
  logic        counter_rst;
  logic        mmio_req_valid;
  logic        mmio_req_ready;
  logic        mmio_req_we;
  logic [3:0]  mmio_req_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_resp_valid;
  logic [31:0] mmio_rdata;

  int tests = 0;
  int fails = 0;
  int crst_hi = 0;

  perf_counter_ctrl #(.XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .retire_valid    (retire_valid),
    .instr_cnt       (instr_cnt),
    .instr_stop      (instr_stop),
    .counter_rst     (counter_rst),
    .mmio_req_valid  (mmio_req_valid),
    .mmio_req_ready  (mmio_req_ready),
    .mmio_req_we     (mmio_req_we),
    .mmio_req_addr   (mmio_req_addr),
    .mmio_wdata      (mmio_wdata),
    .mmio_resp_valid (mmio_resp_valid),
    .mmio_rdata      (mmio_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream instruction counter: synchronous clear wins over counting.
  initial instr_cnt = 32'd0;
  always @(posedge clk) begin
    if (counter_rst) begin
      instr_cnt <= 32'd0;
    end else if (!instr_stop) begin
      instr_cnt <= instr_cnt + 32'd1;
    end
  end

  // Count cycles with counter_rst high outside reset.
  always @(negedge clk) begin
    if (rst_n && counter_rst) crst_hi <= crst_hi + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one request and returns at the negedge where
  // the response is seen. lat = negedges from accept edge to response, -1 on timeout.
  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    int n;
    n = 0;
    rd = 32'd0;
    mmio_req_valid = 1'b1;
    mmio_req_we    = we;
    mmio_req_addr  = addr;
    mmio_wdata     = wd;
    while (!mmio_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mmio_req_ready) begin
      mmio_req_valid = 1'b0;
      lat = -1;
      $display("FAIL ready_timeout: got ready 0 expected 1");
      fails++;
      tests++;
    end else begin
      @(negedge clk);
      mmio_req_valid = 1'b0;
      mmio_req_we    = 1'b0;
      mmio_wdata     = 32'd0;
      lat = 1;
      while (!mmio_resp_valid && lat < 4) begin
        @(negedge clk);
        lat++;
      end
      if (mmio_resp_valid) begin
        rd = mmio_rdata;
      end else begin
        lat = -1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] rd2;
    logic [31:0] m0;
    int lat;
    int bad;
    int c0;

    rst_n          = 1'b0;
    retire_valid   = 1'b1;
    mmio_req_valid = 1'b0;
    mmio_req_we    = 1'b0;
    mmio_req_addr  = 4'h0;
    mmio_wdata     = 32'd0;

    // Reset values and release
    repeat (3) @(negedge clk);
    check_val("rst_counter_rst", 32'(counter_rst), 32'd1);
    check_val("rst_ready", 32'(mmio_req_ready), 32'd0);
    check_val("rst_resp_valid", 32'(mmio_resp_valid), 32'd0);
    check_val("rst_rdata", mmio_rdata, 32'd0);
    rst_n = 1'b1;
    check_val("rel_counter_rst_held", 32'(counter_rst), 32'd1);
    @(negedge clk);
    check_val("rel_counter_rst_drop", 32'(counter_rst), 32'd0);
    check_val("rel_ready_rise", 32'(mmio_req_ready), 32'd1);
    repeat (9) @(negedge clk);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    check_val("rel_cycle_10", rd, 32'd10);
    check_val("rd_latency", 32'(lat), 32'd1);
    bus_xfer(1'b0, 4'h4, 32'd0, rd, lat);
    check_val("rel_instr_9", rd, 32'd9);

    // Clear (no retirement), then a consistent CYCLE/INSTR pair
    retire_valid = 1'b0;
    bus_xfer(1'b1, 4'h8, 32'h2, rd, lat);
    check_val("clr0_latency", 32'(lat), 32'd2);
    check_val("clr0_rdata", rd, 32'd0);
    check_val("clr0_instr_zero", instr_cnt, 32'd0);
    for (int i = 0; i < 8; i++) begin
      retire_valid = (i % 2 == 0);
      @(negedge clk);
    end
    retire_valid = 1'b1;  // retirement on the accept edge must not be captured
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    retire_valid = 1'b0;
    check_val("pair_cycle", rd, 32'd8);
    bus_xfer(1'b0, 4'hC, 32'd0, rd, lat);
    check_val("pair_status_snap", rd, 32'd2);
    bus_xfer(1'b0, 4'h4, 32'd0, rd, lat);
    check_val("pair_instr", rd, 32'd4);
    bus_xfer(1'b0, 4'hD, 32'd0, rd, lat);  // addr[1:0] ignored
    check_val("pair_status_after", rd, 32'd0);

    // Clear while retiring
    retire_valid = 1'b1;
    c0 = crst_hi;
    bus_xfer(1'b1, 4'h8, 32'h2, rd, lat);
    check_val("clr_latency", 32'(lat), 32'd2);
    check_val("clr_instr_zero", instr_cnt, 32'd0);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    check_val("clr_cycle_small", rd, 32'd1);
    check_val("clr_pulse_width", 32'(crst_hi - c0), 32'd1);
    bus_xfer(1'b0, 4'h8, 32'd0, rd, lat);
    check_val("clr_ctrl_readback", rd, 32'd0);

    // Freeze together with clear: counter parks at 0
    retire_valid = 1'b0;
    bus_xfer(1'b1, 4'h8, 32'h3, rd, lat);
    repeat (20) @(negedge clk);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    check_val("frzclr_cycle_a", rd, 32'd0);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    check_val("frzclr_cycle_b", rd, 32'd0);
    bus_xfer(1'b0, 4'hC, 32'd0, rd, lat);
    check_val("frzclr_status", rd, 32'd3);
    bus_xfer(1'b1, 4'h0, 32'h1234, rd, lat);
    check_val("wr_cycle_rdata", rd, 32'd0);
    check_val("wr_cycle_latency", 32'(lat), 32'd1);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    check_val("wr_cycle_ignored", rd, 32'd0);
    bus_xfer(1'b1, 4'h8, 32'h0, rd, lat);

    // Freeze while retiring
    retire_valid = 1'b1;
    bus_xfer(1'b1, 4'h8, 32'h1, rd, lat);
    m0 = instr_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_stop !== 1'b1) bad++;
    end
    check_val("frz_instr_stop", 32'(bad), 32'd0);
    check_val("frz_instr_hold", instr_cnt, m0);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    bus_xfer(1'b0, 4'h0, 32'd0, rd2, lat);
    check_val("frz_cycle_equal", rd2, rd);
    bus_xfer(1'b0, 4'h8, 32'd0, rd, lat);
    check_val("frz_ctrl_readback", rd, 32'd1);
    bus_xfer(1'b1, 4'h8, 32'h0, rd, lat);
    @(negedge clk);
    check_val("unfrz_instr_stop", 32'(instr_stop), 32'd0);

    // Wrap
    force dut.cycle_r = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_r;
    repeat (2) @(negedge clk);
    bus_xfer(1'b0, 4'h0, 32'd0, rd, lat);
    check_val("wrap_cycle", 32'((rd == 32'd0) || (rd == 32'd1)), 32'd1);

    // Reset in the cycle after a read accept aborts the response
    @(negedge clk);
    mmio_req_valid = 1'b1;
    mmio_req_we    = 1'b0;
    mmio_req_addr  = 4'h0;
    check_val("abort_ready_pre", 32'(mmio_req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    mmio_req_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mmio_resp_valid !== 1'b0) bad++;
    end
    check_val("abort_no_resp", 32'(bad), 32'd0);
    check_val("abort_counter_rst", 32'(counter_rst), 32'd1);
    check_val("abort_ready", 32'(mmio_req_ready), 32'd0);
    check_val("abort_rdata", mmio_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_ready_back", 32'(mmio_req_ready), 32'd1);
    bus_xfer(1'b0, 4'h4, 32'd0, rd, lat);
    check_val("abort_snap_reset", rd, 32'd0);
    bus_xfer(1'b0, 4'hC, 32'd0, rd, lat);
    check_val("abort_status_reset", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

Memory-mapped control and readout front-end for the core's instruction counter. Sits between the MMIO bus and the instruction counter: drives its `instr_stop` and `counter_rst` inputs from retire status and software commands. Consumes its `instr_cnt` output, pairing it with an internal cycle counter so software can read a consistent CYCLE/INSTR pair for CPI measurement.

## Interface
- `XLEN`, 32, counter and data width.

- `clk`  in  1  core clock.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `retire_valid`  in  1  one instruction retires this cycle.
- `instr_cnt`  in  XLEN  current instruction count from the instruction counter.
- `instr_stop`  out  1  to counter; high = hold count.
- `counter_rst`  out  1  to counter; synchronous clear request.
- `mmio_req_valid`  in  1  bus request present.
- `mmio_req_ready`  out  1  block can accept a request.
- `mmio_req_we`  in  1  1 = write, 0 = read.
- `mmio_req_addr`  in  4  byte offset; only `[3:2]` decoded, `[1:0]` ignored.
- `mmio_wdata`  in  XLEN  write data.
- `mmio_resp_valid`  out  1  one-cycle response strobe.
- `mmio_rdata`  out  XLEN  read data, valid with `mmio_resp_valid`.

## Operation
- Register map:
  - 0x0 CYCLE: RO, live cycle counter.
  - 0x4 INSTR: RO, instruction snapshot.
  - 0x8 CTRL: RW. Bit0 `freeze`. Bit1 `clear`, write-1 action, always reads 0.
  - 0xC STATUS: RO. Bit0 `freeze`, bit1 `snap_valid`.
- `instr_stop = ~retire_valid | freeze` (combinational).
- Cycle counter increments every cycle while `freeze=0`.
  - Wraps `2^XLEN-1 -> 0`.
  - Holds while `freeze=1`.
- Reading CYCLE:
  - Returns the cycle counter value at the accept edge.
  - On the same edge, latches `instr_cnt` into the snapshot register and sets `snap_valid`.
- Reading INSTR returns the snapshot and clears `snap_valid`.
  - Reading INSTR with `snap_valid=0` returns the stale snapshot (0 after reset).
- Writes to CYCLE, INSTR and STATUS are ignored but still produce a response with rdata 0.
- A write to CTRL:
  - Updates `freeze` from `wdata[0]`.
  - If `wdata[1]=1`, also starts a clear.
- FSM states IDLE, CLR, RESP:
  - IDLE: `mmio_req_ready=1`. Accepting a request goes to RESP, or to CLR if it is a clear write.
  - CLR: `counter_rst=1` for exactly one cycle. The cycle counter, snapshot and `snap_valid` clear on that edge. Next state RESP.
  - RESP: `mmio_resp_valid=1` for one cycle with `mmio_rdata` driven. `mmio_req_ready=0`. Next state IDLE.
- During a CTRL write, `freeze` takes effect at the accept edge, before the clear.
- If a retirement coincides with `counter_rst=1`, the clear wins: the count becomes 0.
- The response has no backpressure; the bus must take it.

## Timing
- Reset values while `rst_n` is low:
  - `counter_rst=1`, so the downstream counter clears on every clock while reset is held.
  - `mmio_req_ready=0`, `mmio_resp_valid=0`, `mmio_rdata=0`.
  - `freeze=0`, cycle counter 0, snapshot 0, `snap_valid=0`, state IDLE.
- After `rst_n` rises:
  - `counter_rst` drops at the first rising edge.
  - `mmio_req_ready` rises at that same edge.
- A request is accepted on a rising edge with `valid & ready`.
- Read/ignored write latency: `mmio_resp_valid` is high in the cycle immediately after the accept edge. Next accept is possible 2 cycles after the previous accept.
- Clear latency:
  - `counter_rst` is high in cycle +1 after accept.
  - Response in cycle +2.
  - `instr_cnt` reads 0 from cycle +2.
- `instr_cnt` lags `retire_valid` by one cycle. A CYCLE read therefore snapshots the retirements up to the cycle before accept.
- An asynchronous `rst_n` assertion mid-transaction aborts it. No response is issued and all state returns to reset values.

## Test plan
- Reset release: hold `rst_n=0` for 3 cycles, then release with `retire_valid=1` constant.
  - `counter_rst=1` through release, 0 after the first edge.
  - A CYCLE read accepted 10 cycles later returns 10 (±0 per the defined edge).
- Consistent pair: retire every other cycle, read CYCLE then INSTR.
  - INSTR equals the number of retire pulses up to the cycle before the CYCLE accept.
  - STATUS bit1 reads 1 between the two reads and 0 after.
- Freeze: write CTRL=0x1, wait 20 cycles, read CYCLE twice.
  - Both reads return the same value.
  - `instr_stop=1` throughout, even with `retire_valid=1`.
- Clear: write CTRL=0x2 while `retire_valid=1`.
  - `counter_rst` is high for exactly one cycle.
  - A subsequent CYCLE read returns a small value (< 5).
  - CTRL reads back 0.
- Wrap: preload the cycle counter near 0xFFFFFFFE (force), run 3 cycles, read CYCLE; the value has wrapped to 0x00000000 or 0x00000001.
- Misc: write CYCLE with 0x1234 -> response with rdata 0, counter unaffected.
  - Assert `rst_n` in the cycle after accepting a read -> no `mmio_resp_valid` is issued.
